add_rs: RTL

ADD_RS -- requirements
Module: add_rs

---
 rtl/add_rs_pkg.sv | 16 +
 rtl/add_rs_entry.sv | 58 +++++
 rtl/add_rs.sv | 91 +++++++++
 3 files changed

// File: rtl/add_rs_pkg.sv
// Shared add/sub ALU constants and the reservation-station issue request.
package add_rs_pkg;
  localparam int          TAG_W     = 4;
  localparam int          DATA_W    = 32;
  localparam logic [TAG_W-1:0] TAG_READY = '0;   // tag 0 means "operand present"
  localparam logic        ALUAdd    = 1'b0;
  localparam logic        ALUSub    = 1'b1;

  typedef struct packed {
    logic              op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
  } rs_req_t;
endpackage

// File: rtl/add_rs_entry.sv
// One reservation-station entry: operand storage, CDB snoop, ready flag.
module rs_entry
  import add_rs_pkg::*;
(
  input  logic              clk,
  input  logic              nRST,
  input  logic              alloc,
  input  rs_req_t           req,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              clear,
  output logic              busy,
  output logic              ready,
  output logic              op,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk
);
  logic [TAG_W-1:0] qj, qk;
  logic             cdb_live;

  // tag 0 on the bus can never wake anything
  assign cdb_live = cdb_valid && (cdb_tag != TAG_READY);
  assign ready    = busy && (qj == TAG_READY) && (qk == TAG_READY);

  // capture on issue (with same-cycle CDB bypass), otherwise snoop and free
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy <= 1'b0;
      op   <= ALUAdd;
      vj   <= '0;
      vk   <= '0;
      qj   <= TAG_READY;
      qk   <= TAG_READY;
    end else if (alloc) begin
      busy <= 1'b1;
      op   <= req.op;
      if (cdb_live && req.qj == cdb_tag) begin
        vj <= cdb_data; qj <= TAG_READY;
      end else begin
        vj <= req.vj;   qj <= req.qj;
      end
      if (cdb_live && req.qk == cdb_tag) begin
        vk <= cdb_data; qk <= TAG_READY;
      end else begin
        vk <= req.vk;   qk <= req.qk;
      end
    end else begin
      if (clear) busy <= 1'b0;
      if (busy && cdb_live && qj == cdb_tag) begin
        vj <= cdb_data; qj <= TAG_READY;
      end
      if (busy && cdb_live && qk == cdb_tag) begin
        vk <= cdb_data; qk <= TAG_READY;
      end
    end
  end
endmodule

// File: rtl/add_rs.sv
// Add/sub reservation station: DEPTH entries, lowest-free allocation,
// lowest-ready dispatch to a single-issue ALU.
module add_rs
  import add_rs_pkg::*;
#(
  parameter int               DEPTH    = 3,
  parameter logic [TAG_W-1:0] BASE_TAG = 4'd1
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              issueValid,
  input  logic              issueOp,
  input  logic [DATA_W-1:0] issueVj,
  input  logic [DATA_W-1:0] issueVk,
  input  logic [TAG_W-1:0]  issueQj,
  input  logic [TAG_W-1:0]  issueQk,
  output logic [TAG_W-1:0]  issueTag,
  output logic              full,
  input  logic              cdbValid,
  input  logic [TAG_W-1:0]  cdbTag,
  input  logic [DATA_W-1:0] cdbData,
  input  logic              aluAvailable,
  output logic              aluWEN,
  output logic              aluOp,
  output logic [DATA_W-1:0] aluData1,
  output logic [DATA_W-1:0] aluData2,
  output logic [TAG_W-1:0]  aluTag
);
  rs_req_t                        req;
  logic [DEPTH-1:0]               busy, ready, op, alloc, clear;
  logic [DEPTH-1:0][DATA_W-1:0]   vj, vk;

  assign req  = '{op: issueOp, vj: issueVj, vk: issueVk, qj: issueQj, qk: issueQk};
  assign full = &busy;

  // allocation: lowest-index free entry, only when not full (pre-edge state)
  always_comb begin
    logic found;
    found    = 1'b0;
    alloc    = '0;
    issueTag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy[i] && !found) begin
        found    = 1'b1;
        alloc[i] = issueValid;
        issueTag = BASE_TAG + TAG_W'(i);
      end
    end
  end

  // dispatch: lowest-index ready entry drives the ALU; freed on handshake
  always_comb begin
    logic found;
    found    = 1'b0;
    clear    = '0;
    aluWEN   = 1'b0;
    aluOp    = ALUAdd;
    aluData1 = '0;
    aluData2 = '0;
    aluTag   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !found) begin
        found    = 1'b1;
        aluWEN   = 1'b1;
        aluOp    = op[i];
        aluData1 = vj[i];
        aluData2 = vk[i];
        aluTag   = BASE_TAG + TAG_W'(i);
        clear[i] = aluAvailable;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_entry u_ent (
      .clk       (clk),
      .nRST      (nRST),
      .alloc     (alloc[g]),
      .req       (req),
      .cdb_valid (cdbValid),
      .cdb_tag   (cdbTag),
      .cdb_data  (cdbData),
      .clear     (clear[g]),
      .busy      (busy[g]),
      .ready     (ready[g]),
      .op        (op[g]),
      .vj        (vj[g]),
      .vk        (vk[g])
    );
  end
endmodule
